// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered hex value, leading-zero
// blanking, per-digit decimal point and PWM brightness on common-anode digits.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_W      = 11,
    parameter int BRIGHT_W   = 3
) (
    input  logic                    x1,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    enable,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [7:0]              SSD,
    output logic                    frame_done,
    output logic                    load_pending
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        slot_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] active;

    logic                    slot_tick;
    logic                    frame_wrap;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   anode_sel;
    logic [IDX_W-1:0]        top_idx;
    logic                    blank_digit;
    logic                    pwm_lit;
    logic [6:0]              seg_code;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign slot_tick  = (slot_cnt == '1);
    assign frame_wrap = slot_tick && (digit_idx == LAST_IDX);

    always_ff @(posedge x1 or posedge rst) begin
        if (rst) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_tick) begin
                if (digit_idx == LAST_IDX) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + 1'b1;
                end
            end
        end
    end

    // A load on the wrap cycle commits the previous shadow first; the new value then waits a frame.
    always_ff @(posedge x1 or posedge rst) begin
        if (rst) begin
            shadow       <= '0;
            active       <= '0;
            load_pending <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            if (frame_wrap && load_pending) begin
                active       <= shadow;
                load_pending <= 1'b0;
            end
            if (load) begin
                shadow       <= value;
                load_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        anode_sel  = '1;
        top_idx    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nibble   = active[4*i +: 4];
                cur_dp       = dp_en[i];
                anode_sel[i] = 1'b0;
            end
            if (active[4*i +: 4] != 4'h0) begin
                top_idx = IDX_W'(i);
            end
        end
    end

    // top_idx is 0 for an all-zero value, so digit 0 can never satisfy the blanking test.
    assign blank_digit = blank_lz && (digit_idx > top_idx);
    assign pwm_lit     = enable &&
                         ((brightness == '1) || (slot_cnt[DIV_W-1 -: BRIGHT_W] < brightness));
    assign seg_code    = blank_digit ? 7'h7F : hex_to_seg(cur_nibble);

    always_ff @(posedge x1 or posedge rst) begin
        if (rst) begin
            anodes <= '1;
            SSD    <= 8'hFF;
        end else if (pwm_lit) begin
            anodes <= anode_sel;
            SSD    <= {~cur_dp, seg_code};
        end else begin
            anodes <= '1;
            SSD    <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl (4 digits, 16-clock slots, 2-bit brightness):
// frame-level reference model compared every cycle, plus directed literal checks.
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  dp_en = 4'b0000;
    logic        blank_lz = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic        enable = 1'b1;
    logic [3:0]  anodes;
    logic [7:0]  SSD;
    logic        frame_done;
    logic        load_pending;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    ssd_scan_ctrl #(
        .NUM_DIGITS(4),
        .DIV_W(4),
        .BRIGHT_W(2)
    ) dut (
        .x1(clk),
        .rst(rst),
        .value(value),
        .load(load),
        .dp_en(dp_en),
        .blank_lz(blank_lz),
        .brightness(brightness),
        .enable(enable),
        .anodes(anodes),
        .SSD(SSD),
        .frame_done(frame_done),
        .load_pending(load_pending)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: m_k counts clock edges since reset; digit and slot follow arithmetically.
    int          m_k;
    logic [15:0] m_shadow, m_active;
    bit          m_pending;
    logic [3:0]  exp_anodes;
    logic [7:0]  exp_ssd;
    logic        exp_fd, exp_lp;
    int          m_slot, m_idx, m_top;
    logic [3:0]  m_nib;
    bit          m_lit, m_blank;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = 0; m_shadow = 16'h0; m_active = 16'h0; m_pending = 1'b0;
            exp_anodes = 4'hF; exp_ssd = 8'hFF; exp_fd = 1'b0; exp_lp = 1'b0;
        end else begin
            m_slot  = m_k % 16;
            m_idx   = (m_k / 16) % 4;
            m_lit   = enable && (brightness == 2'd3 || (m_slot / 4) < int'(brightness));
            m_nib   = 4'(m_active >> (4 * m_idx));
            m_top   = (m_active >= 16'h1000) ? 3 : (m_active >= 16'h0100) ? 2 :
                      (m_active >= 16'h0010) ? 1 : 0;
            m_blank = blank_lz && (m_idx > m_top);
            exp_anodes = m_lit ? ~(4'b0001 << m_idx) : 4'hF;
            exp_ssd    = m_lit ? {~dp_en[m_idx], m_blank ? 7'h7F : seg_tab[m_nib][6:0]} : 8'hFF;
            exp_fd     = (m_k % 64 == 63);
            if (m_k % 64 == 63 && m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (load) begin
                m_shadow  = value;
                m_pending = 1'b1;
            end
            exp_lp = m_pending;
            m_k++;
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_anodes", 16'(anodes), 16'(exp_anodes));
            checkOutput("model_ssd", 16'(SSD), 16'(exp_ssd));
            checkOutput("model_frame_done", 16'(frame_done), 16'(exp_fd));
            checkOutput("model_load_pending", 16'(load_pending), 16'(exp_lp));
        end
    end

    // Returns at the falling edge after clock edge number 'target' since reset release.
    task automatic waitK(input int target);
        int guard;
        guard = 0;
        while (m_k != target + 1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (m_k != target + 1) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitK timeout: at edge %0d expected edge %0d", m_k - 1, target);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [15:0] v);
        waitK(k);
        value = v;
        load  = 1'b1;
        waitK(k + 1);
        load  = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        check_en = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_anodes", 16'(anodes), 16'h000F);
        checkOutput("reset_ssd", 16'(SSD), 16'h00FF);
        checkOutput("reset_lp", 16'(load_pending), 16'h0000);
        rst = 1'b0;

        waitK(0);   checkOutput("scan_d0_anodes", 16'(anodes), 16'h000E);
                    checkOutput("scan_d0_ssd", 16'(SSD), 16'h00C0);
        waitK(16);  checkOutput("scan_d1_anodes", 16'(anodes), 16'h000D);
        waitK(32);  checkOutput("scan_d2_anodes", 16'(anodes), 16'h000B);
        waitK(48);  checkOutput("scan_d3_anodes", 16'(anodes), 16'h0007);
        waitK(63);  checkOutput("frame_done_pulse", 16'(frame_done), 16'h0001);
        waitK(64);  checkOutput("frame_done_low", 16'(frame_done), 16'h0000);

        applyStimulus(70, 16'h12AF);
        checkOutput("load_pending_set", 16'(load_pending), 16'h0001);
        waitK(80);  checkOutput("no_tear_d1", 16'(SSD), 16'h00C0);
        waitK(128); checkOutput("commit_d0", 16'(SSD), 16'h008E);
                    checkOutput("commit_lp_clear", 16'(load_pending), 16'h0000);
        waitK(144); checkOutput("commit_d1", 16'(SSD), 16'h0088);
        waitK(160); checkOutput("commit_d2", 16'(SSD), 16'h00A4);
        waitK(176); checkOutput("commit_d3", 16'(SSD), 16'h00F9);

        waitK(199);
        blank_lz = 1'b1;
        dp_en    = 4'b0100;
        applyStimulus(200, 16'h0005);
        waitK(256); checkOutput("blank_d0", 16'(SSD), 16'h0092);
        waitK(272); checkOutput("blank_d1", 16'(SSD), 16'h00FF);
        waitK(288); checkOutput("blank_d2_dp", 16'(SSD), 16'h007F);
        waitK(304); checkOutput("blank_d3", 16'(SSD), 16'h00FF);
                    checkOutput("blank_d3_anodes", 16'(anodes), 16'h0007);
        applyStimulus(310, 16'h0000);
        waitK(320); checkOutput("zero_d0", 16'(SSD), 16'h00C0);
        waitK(336); checkOutput("zero_d1", 16'(SSD), 16'h00FF);

        waitK(351); brightness = 2'd1;
        waitK(352); checkOutput("pwm1_slot0", 16'(anodes), 16'h000B);
        waitK(355); checkOutput("pwm1_slot3", 16'(anodes), 16'h000B);
        waitK(356); checkOutput("pwm1_slot4", 16'(anodes), 16'h000F);
                    checkOutput("pwm1_slot4_ssd", 16'(SSD), 16'h00FF);
        waitK(368); checkOutput("pwm1_d3_slot0", 16'(anodes), 16'h0007);
        waitK(383); brightness = 2'd0;
        waitK(384); checkOutput("pwm0_dark", 16'(anodes), 16'h000F);
        waitK(399); brightness = 2'd3;

        applyStimulus(420, 16'h3333);
        waitK(446); value = 16'h4444; load = 1'b1;
        waitK(447); load = 1'b0;
        waitK(448); checkOutput("wrap_load_old", 16'(SSD), 16'h00B0);
                    checkOutput("wrap_load_pending", 16'(load_pending), 16'h0001);
        waitK(512); checkOutput("wrap_load_new", 16'(SSD), 16'h0099);
                    checkOutput("wrap_load_lp_clear", 16'(load_pending), 16'h0000);

        applyStimulus(520, 16'h0006);
        applyStimulus(530, 16'h0007);
        waitK(576); checkOutput("two_loads_last", 16'(SSD), 16'h00F8);
        waitK(592); checkOutput("two_loads_d1", 16'(SSD), 16'h00FF);

        applyStimulus(600, 16'h0009);
        waitK(610);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_anodes", 16'(anodes), 16'h000F);
        checkOutput("async_rst_ssd", 16'(SSD), 16'h00FF);
        checkOutput("async_rst_lp", 16'(load_pending), 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        waitK(0);   checkOutput("rerun_d0_anodes", 16'(anodes), 16'h000E);
                    checkOutput("rerun_d0_ssd", 16'(SSD), 16'h00C0);
        waitK(20);  checkOutput("rerun_d1_ssd", 16'(SSD), 16'h00FF);
        waitK(70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
